wvb_rd_addr_seq_mc: RTL and testbench

Multi-channel waveform-buffer read-address sequencer. It serves P_N_CHAN waveform buffers with one read port. Each buffer has its own read pointer. A header read selects one channel, loads that channel's pointer with the event's start address after a programmable header latency, and then steps the pointer per word read. The address space is a ring of arbitrary depth, so a wrapped event (stop < start) is handled natively. The block sits between the header FIFOs / readout arbiter and the waveform-buffer RAM read ports, and adds words-remaining, last-word and protocol-error reporting.

---
 rtl/wvb_rd_pkg.sv | 21 ++
 rtl/wvb_rd_ptr_bank.sv | 33 +++
 rtl/wvb_rd_addr_seq_mc.sv | 158 +++++++++++++++
 tb/tb_wvb_rd_addr_seq_mc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wvb_rd_pkg.sv
// Shared types and ring-address helpers for the multi-channel waveform-buffer
// read-address sequencer.
package wvb_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR_WAIT,
    READ
  } state_e;

  // Helpers work at 32 bits; callers narrow the result with a size cast.
  function automatic logic [31:0] wrap_inc(input logic [31:0] addr, input logic [31:0] depth);
    return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

  function automatic logic [31:0] ring_span(input logic [31:0] start, input logic [31:0] stop,
                                            input logic [31:0] depth);
    return (stop >= start) ? stop - start + 32'd1 : depth - start + stop + 32'd1;
  endfunction

endpackage

// File: rtl/wvb_rd_ptr_bank.sv
// Bank of per-channel read pointers with one shared write port; pointers
// reset to the last ring address so the first event's stop+1 lands on 0.
module wvb_rd_ptr_bank #(
  parameter int P_ADR_WIDTH = 12,
  parameter int P_DEPTH     = 4096,
  parameter int P_N_CHAN    = 4,
  parameter int P_CW        = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [P_CW-1:0]                 sel_i,
  input  logic [P_ADR_WIDTH-1:0]          data_i,
  input  logic                            we_i,
  output logic [P_N_CHAN*P_ADR_WIDTH-1:0] ptr_o
);

  logic [P_ADR_WIDTH-1:0] ptr_q [P_N_CHAN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < P_N_CHAN; k++) ptr_q[k] <= P_ADR_WIDTH'(P_DEPTH - 1);
    end else if (we_i) begin
      for (int k = 0; k < P_N_CHAN; k++) begin
        if (sel_i == P_CW'(k)) ptr_q[k] <= data_i;
      end
    end
  end

  for (genvar g = 0; g < P_N_CHAN; g++) begin : g_lane
    assign ptr_o[g*P_ADR_WIDTH +: P_ADR_WIDTH] = ptr_q[g];
  end

endmodule

// File: rtl/wvb_rd_addr_seq_mc.sv
// Multi-channel waveform-buffer read-address sequencer: header-latency wait,
// per-word pointer stepping on a ring, words-remaining and error reporting.
module wvb_rd_addr_seq_mc
  import wvb_rd_pkg::*;
#(
  parameter int P_ADR_WIDTH = 12,
  parameter int P_DEPTH     = 4096,
  parameter int P_N_CHAN    = 4,
  parameter int P_HDR_WAIT  = 2,
  localparam int P_CW       = (P_N_CHAN > 1) ? $clog2(P_N_CHAN) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [P_CW-1:0]                 chan_sel,
  input  logic                            hdr_rdreq,
  input  logic [P_ADR_WIDTH-1:0]          hdr_start_addr,
  input  logic [P_ADR_WIDTH-1:0]          hdr_stop_addr,
  input  logic                            wvb_rdreq,
  input  logic                            wvb_rddone,
  output logic [P_N_CHAN*P_ADR_WIDTH-1:0] rd_addr,
  output logic [P_CW-1:0]                 active_chan,
  output logic                            busy,
  output logic [P_ADR_WIDTH:0]            words_left,
  output logic                            last_word,
  output logic                            err_overrun,
  output logic                            err_proto
);

  localparam int CNT_W = $clog2(P_HDR_WAIT + 1);
  localparam int WL_W  = P_ADR_WIDTH + 1;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [P_CW-1:0]        chan_q, chan_d;
  logic [P_ADR_WIDTH-1:0] stop_q, stop_d;
  logic [WL_W-1:0]        words_q, words_d;
  logic                   last_q, last_d;
  logic                   ovr_q, ovr_d;
  logic                   proto_q, proto_d;

  logic                   ptr_we;
  logic [P_ADR_WIDTH-1:0] ptr_wdata;
  logic [P_ADR_WIDTH-1:0] lanes [P_N_CHAN];
  logic [P_ADR_WIDTH-1:0] cur_ptr;

  wvb_rd_ptr_bank #(
    .P_ADR_WIDTH(P_ADR_WIDTH),
    .P_DEPTH    (P_DEPTH),
    .P_N_CHAN   (P_N_CHAN),
    .P_CW       (P_CW)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .sel_i (chan_q),
    .data_i(ptr_wdata),
    .we_i  (ptr_we),
    .ptr_o (rd_addr)
  );

  for (genvar g = 0; g < P_N_CHAN; g++) begin : g_cur
    assign lanes[g] = rd_addr[g*P_ADR_WIDTH +: P_ADR_WIDTH];
  end
  assign cur_ptr = lanes[chan_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    chan_d    = chan_q;
    stop_d    = stop_q;
    words_d   = words_q;
    ptr_we    = 1'b0;
    ptr_wdata = '0;
    ovr_d     = 1'b0;
    proto_d   = 1'b0;

    case (state_q)
      IDLE: begin
        proto_d = wvb_rdreq | wvb_rddone;
        if (hdr_rdreq) begin
          state_d = HDR_WAIT;
          chan_d  = chan_sel;
          cnt_d   = CNT_W'(1);
        end
      end
      HDR_WAIT: begin
        proto_d = hdr_rdreq | wvb_rdreq | wvb_rddone;
        if (hdr_rdreq) begin
          chan_d = chan_sel;
          cnt_d  = CNT_W'(1);
        end else if (cnt_q == CNT_W'(P_HDR_WAIT)) begin
          state_d   = READ;
          ptr_we    = 1'b1;
          ptr_wdata = hdr_start_addr;
          stop_d    = hdr_stop_addr;
          words_d   = WL_W'(ring_span(32'(hdr_start_addr), 32'(hdr_stop_addr), 32'(P_DEPTH)));
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ: begin
        proto_d = hdr_rdreq;
        // A restart abandons the current event; its pointer stays where it is.
        if (hdr_rdreq) begin
          state_d = HDR_WAIT;
          chan_d  = chan_sel;
          cnt_d   = CNT_W'(1);
          words_d = '0;
        end else if (wvb_rddone) begin
          state_d   = IDLE;
          ptr_we    = 1'b1;
          ptr_wdata = P_ADR_WIDTH'(wrap_inc(32'(stop_q), 32'(P_DEPTH)));
          words_d   = '0;
        end else if (wvb_rdreq) begin
          if (words_q != '0) begin
            ptr_we    = 1'b1;
            ptr_wdata = P_ADR_WIDTH'(wrap_inc(32'(cur_ptr), 32'(P_DEPTH)));
            words_d   = words_q - WL_W'(1);
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    last_d = (state_d == READ) && (words_d == WL_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      stop_q  <= '0;
      words_q <= '0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      stop_q  <= stop_d;
      words_q <= words_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
      proto_q <= proto_d;
    end
  end

  assign active_chan = chan_q;
  assign busy        = (state_q != IDLE);
  assign words_left  = words_q;
  assign last_word   = last_q;
  assign err_overrun = ovr_q;
  assign err_proto   = proto_q;

endmodule

// File: tb/tb_wvb_rd_addr_seq_mc.sv
// Scoreboard bench: two sequencers (ring depth 4096 and 3000) share stimulus;
// expected outputs are queued per cycle and compared one cycle later.
module tb_wvb_rd_addr_seq_mc;

  localparam int AW = 12;
  localparam int NC = 4;
  localparam int HW = 2;

  logic clk = 1'b0;
  logic rst, hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic [1:0] chan_sel;
  logic [AW-1:0] hdr_start_addr, hdr_stop_addr;

  logic [NC*AW-1:0] rdA, rdB;
  logic [1:0] actA, actB;
  logic busyA, busyB, lastA, lastB, ovA, ovB, prA, prB;
  logic [AW:0] wlA, wlB;

  wvb_rd_addr_seq_mc #(.P_ADR_WIDTH(AW), .P_DEPTH(4096), .P_N_CHAN(NC), .P_HDR_WAIT(HW)) dutA (
    .clk(clk), .rst(rst), .chan_sel(chan_sel), .hdr_rdreq(hdr_rdreq),
    .hdr_start_addr(hdr_start_addr), .hdr_stop_addr(hdr_stop_addr),
    .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone), .rd_addr(rdA), .active_chan(actA),
    .busy(busyA), .words_left(wlA), .last_word(lastA), .err_overrun(ovA), .err_proto(prA));

  wvb_rd_addr_seq_mc #(.P_ADR_WIDTH(AW), .P_DEPTH(3000), .P_N_CHAN(NC), .P_HDR_WAIT(HW)) dutB (
    .clk(clk), .rst(rst), .chan_sel(chan_sel), .hdr_rdreq(hdr_rdreq),
    .hdr_start_addr(hdr_start_addr), .hdr_stop_addr(hdr_stop_addr),
    .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone), .rd_addr(rdB), .active_chan(actB),
    .busy(busyB), .words_left(wlB), .last_word(lastB), .err_overrun(ovB), .err_proto(prB));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          dut;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int nVec = 0;
  int nMis = 0;

  int dep [2] = '{4096, 3000};
  int eLane [2][NC];
  int eWl [2];
  bit eLast [2];
  bit eOv [2];
  bit eProto, eBusy, skipWl;
  int eAct;
  int curCh, curStop;

  function automatic int winc(int a, int d);
    return (a == d - 1) ? 0 : a + 1;
  endfunction

  function automatic int wspan(int s, int e, int d);
    return (e >= s) ? e - s + 1 : d - s + e + 1;
  endfunction

  function automatic logic [31:0] obs(int d, int s);
    logic [NC*AW-1:0] rd;
    rd = (d == 0) ? rdA : rdB;
    case (s)
      0, 1, 2, 3: return 32'(rd[s*AW +: AW]);
      4: return (d == 0) ? 32'(wlA) : 32'(wlB);
      5: return (d == 0) ? 32'(busyA) : 32'(busyB);
      6: return (d == 0) ? 32'(lastA) : 32'(lastB);
      7: return (d == 0) ? 32'(ovA) : 32'(ovB);
      8: return (d == 0) ? 32'(prA) : 32'(prB);
      default: return (d == 0) ? 32'(actA) : 32'(actB);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int d, input int s, input string nm, input int v);
    exp_t e;
    e.tag = $sformatf("t%0t_d%0d_%s", $time, d, nm);
    e.dut = d;
    e.sig = s;
    e.exp = 32'(v);
    sb.push_back(e);
  endtask

  // One clock: queue the expected post-edge outputs, clock, then drain and compare.
  task automatic applyStimulus();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NC; k++) push(d, k, $sformatf("lane%0d", k), eLane[d][k]);
      if (!skipWl) push(d, 4, "words_left", eWl[d]);
      push(d, 5, "busy", int'(eBusy));
      push(d, 6, "last_word", int'(eLast[d]));
      push(d, 7, "err_overrun", int'(eOv[d]));
      push(d, 8, "err_proto", int'(eProto));
      push(d, 9, "active_chan", eAct);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, obs(e.dut, e.sig), e.exp);
    end
    rst = 1'b0; hdr_rdreq = 1'b0; wvb_rdreq = 1'b0; wvb_rddone = 1'b0;
    eOv = '{0, 0};
    eProto = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NC; k++) eLane[d][k] = dep[d] - 1;
      eWl[d] = 0;
      eLast[d] = 1'b0;
    end
    eBusy = 1'b0;
    eAct = 0;
    applyStimulus();
  endtask

  task automatic hdrReq(input int ch, input int s, input int e);
    bit restart;
    restart = eBusy;
    hdr_rdreq = 1'b1;
    chan_sel = 2'(ch);
    hdr_start_addr = AW'(s);
    hdr_stop_addr = AW'(e);
    eAct = ch;
    eBusy = 1'b1;
    eLast = '{0, 0};
    if (restart) begin
      eProto = 1'b1;
      skipWl = 1'b1;
    end
    applyStimulus();
    for (int i = 1; i < HW; i++) applyStimulus();
    skipWl = 1'b0;
    curCh = ch;
    curStop = e;
    for (int d = 0; d < 2; d++) begin
      eLane[d][ch] = s;
      eWl[d] = wspan(s, e, dep[d]);
      eLast[d] = (eWl[d] == 1);
    end
    applyStimulus();
  endtask

  task automatic readWords(input int n);
    for (int i = 0; i < n; i++) begin
      wvb_rdreq = 1'b1;
      for (int d = 0; d < 2; d++) begin
        if (eWl[d] > 0) begin
          eLane[d][curCh] = winc(eLane[d][curCh], dep[d]);
          eWl[d]--;
        end else begin
          eOv[d] = 1'b1;
        end
        eLast[d] = (eWl[d] == 1);
      end
      applyStimulus();
    end
  endtask

  task automatic finishEvent(input bit withReq);
    wvb_rddone = 1'b1;
    wvb_rdreq = withReq;
    for (int d = 0; d < 2; d++) begin
      eLane[d][curCh] = winc(curStop, dep[d]);
      eWl[d] = 0;
      eLast[d] = 1'b0;
    end
    eBusy = 1'b0;
    applyStimulus();
  endtask

  initial begin
    rst = 1'b1; hdr_rdreq = 1'b0; wvb_rdreq = 1'b0; wvb_rddone = 1'b0;
    chan_sel = '0; hdr_start_addr = '0; hdr_stop_addr = '0;
    eOv = '{0, 0}; eProto = 1'b0; skipWl = 1'b0;

    doReset();

    $display("[TB] basic event chan 2, 100..103");
    hdrReq(2, 100, 103);
    readWords(4);
    finishEvent(1'b0);

    $display("[TB] wrapped event chan 1, 2998..1");
    hdrReq(1, 2998, 1);
    readWords(4);
    finishEvent(1'b0);

    $display("[TB] overrun chan 0, 50..50");
    hdrReq(0, 50, 50);
    readWords(2);
    finishEvent(1'b0);

    $display("[TB] rdreq and rddone together, chan 3");
    hdrReq(3, 10, 12);
    readWords(1);
    finishEvent(1'b1);

    $display("[TB] rdreq and rddone while idle");
    wvb_rdreq = 1'b1;
    eProto = 1'b1;
    applyStimulus();
    wvb_rddone = 1'b1;
    eProto = 1'b1;
    applyStimulus();

    $display("[TB] header restart during READ");
    hdrReq(1, 500, 505);
    readWords(1);
    hdrReq(2, 700, 702);
    readWords(1);
    finishEvent(1'b0);

    $display("[TB] reset mid-event");
    hdrReq(0, 20, 30);
    readWords(2);
    doReset();

    $display("[TB] event after reset");
    hdrReq(3, 4000, 4001);
    readWords(2);
    finishEvent(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
